// File: rtl/c2c_link_arbiter.sv
// rtl/c2c_link_arbiter.sv - master-side round-robin arbiter and handshake controller for the 3-bit Chip2Chip link
//
// Shares one request/ack/valid/data link among N local requesters. A winner
// is picked round-robin from ptr, its payload is latched at grant, and the
// request -> ack -> valid -> ack-release handshake runs against the slave.
// Completion is reported as a one-cycle one-hot pulse on done_vec.
//
// Optional feature macro: C2C_ARB_TIMEOUT_EN
//   defined   : REQ and RELEASE are bounded by TIMEOUT_CYCLES; expiry aborts the
//               transfer with a one-cycle one-hot pulse on err_vec.
//   undefined : no timer; REQ and RELEASE wait indefinitely; err_vec is 0.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   req_vec  [N]      per-requester transfer request, held until done/err
//   data_vec [3N]     per-requester payload, requester i at [3i+2:3i]
//   done_vec [N]      one-hot completion pulse
//   err_vec  [N]      one-hot timeout pulse
//   busy              high whenever the controller is not idle
//   request, valid, data_out[3]   link outputs to the slave
//   ack               link acknowledge from the slave
module c2c_link_arbiter #(
    parameter int N              = 4,
    parameter int PTR_W          = 2,
    parameter int TIMEOUT_CYCLES = 150_000_000,
    parameter int TO_W           = 28
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req_vec,
    input  logic [3*N-1:0]   data_vec,
    output logic [N-1:0]     done_vec,
    output logic [N-1:0]     err_vec,
    output logic             busy,
    output logic             request,
    input  logic             ack,
    output logic             valid,
    output logic [2:0]       data_out
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SEND    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   winner_q, winner_d;
    logic [2:0]         data_lat_q, data_lat_d;
    logic [2:0]         data_out_q, data_out_d;
    logic               request_q, request_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic [N-1:0]       done_q, done_d;

    logic               pick_found;
    logic [PTR_W-1:0]   pick_idx;
    logic [2:0]         pick_data;
    logic [PTR_W-1:0]   next_ptr;
    logic [N-1:0]       winner_onehot;

`ifdef C2C_ARB_TIMEOUT_EN
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0]    timer_q, timer_d;
    logic [N-1:0]       err_q, err_d;
`endif

    // Round-robin search: first asserted request at ptr, ptr+1, ... wrapping at N.
    always_comb begin
        int idx;
        idx        = 0;
        pick_found = 1'b0;
        pick_idx   = '0;
        pick_data  = '0;
        for (int i = 0; i < N; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!pick_found && req_vec[idx]) begin
                pick_found = 1'b1;
                pick_idx   = PTR_W'(idx);
                pick_data  = data_vec[3*idx +: 3];
            end
        end
    end

    // The pointer moves just past the finished winner so a requester that keeps
    // its request high goes to the back of the queue.
    assign next_ptr      = (winner_q == PTR_W'(N - 1)) ? '0 : winner_q + PTR_W'(1);
    assign winner_onehot = N'(1) << winner_q;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        winner_d   = winner_q;
        data_lat_d = data_lat_q;
        data_out_d = data_out_q;
        request_d  = request_q;
        valid_d    = valid_q;
        busy_d     = busy_q;
        done_d     = '0;
`ifdef C2C_ARB_TIMEOUT_EN
        timer_d    = timer_q;
        err_d      = '0;
`endif
        case (state_q)
            IDLE: begin
                // ack is deliberately ignored here; a stale ack must not stall arbitration.
                if (pick_found) begin
                    winner_d   = pick_idx;
                    data_lat_d = pick_data;
                    request_d  = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = REQ;
`ifdef C2C_ARB_TIMEOUT_EN
                    timer_d    = '0;
`endif
                end
            end
            REQ: begin
                if (ack) begin
                    request_d  = 1'b0;
                    valid_d    = 1'b1;
                    data_out_d = data_lat_q;
                    state_d    = SEND;
                end
`ifdef C2C_ARB_TIMEOUT_EN
                else if (timer_q == TO_LAST) begin
                    request_d = 1'b0;
                    valid_d   = 1'b0;
                    err_d     = winner_onehot;
                    ptr_d     = next_ptr;
                    busy_d    = 1'b0;
                    state_d   = IDLE;
                end else begin
                    timer_d = timer_q + TO_W'(1);
                end
`endif
            end
            SEND: begin
                // valid is a single-cycle strobe; data_out is left holding the payload.
                valid_d = 1'b0;
                state_d = RELEASE;
`ifdef C2C_ARB_TIMEOUT_EN
                timer_d = '0;
`endif
            end
            RELEASE: begin
                if (!ack) begin
                    done_d  = winner_onehot;
                    ptr_d   = next_ptr;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
`ifdef C2C_ARB_TIMEOUT_EN
                else if (timer_q == TO_LAST) begin
                    request_d = 1'b0;
                    valid_d   = 1'b0;
                    err_d     = winner_onehot;
                    ptr_d     = next_ptr;
                    busy_d    = 1'b0;
                    state_d   = IDLE;
                end else begin
                    timer_d = timer_q + TO_W'(1);
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            winner_q   <= '0;
            data_lat_q <= '0;
            data_out_q <= '0;
            request_q  <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            winner_q   <= winner_d;
            data_lat_q <= data_lat_d;
            data_out_q <= data_out_d;
            request_q  <= request_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

`ifdef C2C_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            timer_q <= '0;
            err_q   <= '0;
        end else begin
            timer_q <= timer_d;
            err_q   <= err_d;
        end
    end

    assign err_vec = err_q;
`else
    assign err_vec = '0;
`endif

    assign done_vec = done_q;
    assign busy     = busy_q;
    assign request  = request_q;
    assign valid    = valid_q;
    assign data_out = data_out_q;

endmodule

// File: tb/tb_c2c_link_arbiter.sv
// tb/tb_c2c_link_arbiter.sv - directed self-checking bench for c2c_link_arbiter
module tb_c2c_link_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_vec;
    logic [11:0] data_vec;
    logic [3:0]  done_vec;
    logic [3:0]  err_vec;
    logic        busy;
    logic        request;
    logic        ack;
    logic        valid;
    logic [2:0]  data_out;

    logic        ack_model;
    logic        ack_manual;
    logic        slave_en;
    int          slave_d;

    int errors;
    int checks;

    assign ack = slave_en ? ack_model : ack_manual;

    c2c_link_arbiter #(
        .N              (4),
        .PTR_W          (2),
        .TIMEOUT_CYCLES (20),
        .TO_W           (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_vec  (req_vec),
        .data_vec (data_vec),
        .done_vec (done_vec),
        .err_vec  (err_vec),
        .busy     (busy),
        .request  (request),
        .ack      (ack),
        .valid    (valid),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave model: ack rises slave_d cycles after request, held until one cycle after valid.
    initial begin
        int n;
        ack_model = 1'b0;
        forever begin
            @(negedge clk);
            if (slave_en && request) begin
                for (int k = 1; k < slave_d; k++) @(negedge clk);
                ack_model = 1'b1;
                n = 0;
                while (!valid && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                @(negedge clk);
                ack_model = 1'b0;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_valid(output bit ok);
        int n;
        n = 0;
        while (valid !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        ok = (valid === 1'b1);
    endtask

    task automatic wait_done(output bit ok);
        int n;
        n = 0;
        while (done_vec === 4'b0000 && n < 200) begin
            step();
            n++;
        end
        ok = (done_vec !== 4'b0000);
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        slave_en   = 1'b0;
        slave_d    = 1;
        ack_manual = 1'b0;
        req_vec    = '0;
        data_vec   = '0;
        repeat (3) step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({request, valid, busy} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl: request/valid/busy=%b required 000", {request, valid, busy});
        end
        checks++;
        if (data_out !== 3'd0) begin
            errors++;
            $display("FAIL reset_data_out: got %0d required 0", data_out);
        end
        checks++;
        if (done_vec !== 4'b0000 || err_vec !== 4'b0000) begin
            errors++;
            $display("FAIL reset_pulses: done=%b err=%b required 0000/0000", done_vec, err_vec);
        end
    endtask

    task automatic test_single();
        bit ok;
        int n;
        do_reset();
        slave_en = 1'b1;
        slave_d  = 10;
        data_vec = 12'd5;
        req_vec  = 4'b0001;
        step();
        checks++;
        if (request !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_req_latency: request=%b busy=%b required 1 1", request, busy);
        end
        n = 0;
        while (ack !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        checks++;
        if (ack !== 1'b1 || valid !== 1'b0 || request !== 1'b1) begin
            errors++;
            $display("FAIL single_ack_wait: ack=%b valid=%b request=%b required 1 0 1", ack, valid, request);
        end
        step();
        checks++;
        if (valid !== 1'b1 || data_out !== 3'd5 || request !== 1'b0) begin
            errors++;
            $display("FAIL single_valid: valid=%b data=%0d request=%b required 1 5 0", valid, data_out, request);
        end
        step();
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL single_valid_width: valid=%b required 0", valid);
        end
        wait_done(ok);
        checks++;
        if (!ok || done_vec !== 4'b0001 || busy !== 1'b0 || ack !== 1'b0) begin
            errors++;
            $display("FAIL single_done: done=%b busy=%b ack=%b required 0001 0 0", done_vec, busy, ack);
        end
        req_vec = '0;
        step();
        checks++;
        if (done_vec !== 4'b0000 || data_out !== 3'd5) begin
            errors++;
            $display("FAIL single_after: done=%b data=%0d required 0000 5", done_vec, data_out);
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        int exp_idx [5] = '{0, 1, 2, 3, 0};
        logic [2:0] exp_dat;
        logic [3:0] exp_done;
        do_reset();
        slave_en = 1'b1;
        slave_d  = 3;
        data_vec = {3'd4, 3'd3, 3'd2, 3'd1};
        req_vec  = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_dat  = 3'(exp_idx[k] + 1);
            exp_done = 4'b0001 << exp_idx[k];
            wait_valid(ok);
            checks++;
            if (!ok || data_out !== exp_dat) begin
                errors++;
                $display("FAIL rr_data[%0d]: got %0d required %0d", k, data_out, exp_dat);
            end
            wait_done(ok);
            checks++;
            if (!ok || done_vec !== exp_done) begin
                errors++;
                $display("FAIL rr_done[%0d]: got %b required %b", k, done_vec, exp_done);
            end
            if (k == 4) req_vec = '0;
            step();
        end
        slave_en = 1'b0;
    endtask

    task automatic test_data_latch();
        bit ok;
        do_reset();
        slave_en = 1'b1;
        slave_d  = 5;
        data_vec = {3'd0, 3'd6, 3'd0, 3'd0};
        req_vec  = 4'b0100;
        step();
        data_vec = {3'd0, 3'd1, 3'd0, 3'd0};
        req_vec  = 4'b0000;
        wait_valid(ok);
        checks++;
        if (!ok || data_out !== 3'd6) begin
            errors++;
            $display("FAIL latch_data: got %0d required 6", data_out);
        end
        wait_done(ok);
        checks++;
        if (!ok || done_vec !== 4'b0100) begin
            errors++;
            $display("FAIL latch_done: got %b required 0100", done_vec);
        end
        step();
        slave_en = 1'b0;
    endtask

    task automatic test_reset_mid_send();
        bit ok;
        do_reset();
        data_vec = 12'd3;
        req_vec  = 4'b0001;
        step();
        ack_manual = 1'b1;
        step();
        checks++;
        if (valid !== 1'b1) begin
            errors++;
            $display("FAIL midrst_in_send: valid=%b required 1", valid);
        end
        rst_n      = 1'b0;
        ack_manual = 1'b0;
        step();
        checks++;
        if ({valid, request, busy} !== 3'b000 || data_out !== 3'd0) begin
            errors++;
            $display("FAIL midrst_drop: valid/request/busy=%b data=%0d required 000 0", {valid, request, busy}, data_out);
        end
        rst_n    = 1'b1;
        data_vec = {3'd7, 3'd0, 3'd0, 3'd3};
        req_vec  = 4'b1001;
        step();
        ack_manual = 1'b1;
        step();
        checks++;
        if (valid !== 1'b1 || data_out !== 3'd3) begin
            errors++;
            $display("FAIL midrst_winner_data: valid=%b data=%0d required 1 3", valid, data_out);
        end
        ack_manual = 1'b0;
        wait_done(ok);
        checks++;
        if (!ok || done_vec !== 4'b0001) begin
            errors++;
            $display("FAIL midrst_winner_done: got %b required 0001", done_vec);
        end
        req_vec = '0;
        step();
    endtask

`ifdef C2C_ARB_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        int n;
        do_reset();
        data_vec = 12'd0;
        req_vec  = 4'b0010;
        step();
        n = 0;
        while (err_vec === 4'b0000 && n < 100) begin
            step();
            n++;
        end
        checks++;
        if (err_vec !== 4'b0010 || n != 20) begin
            errors++;
            $display("FAIL to_err: err=%b after %0d cycles required 0010 after 20", err_vec, n);
        end
        checks++;
        if (request !== 1'b0 || busy !== 1'b0 || done_vec !== 4'b0000) begin
            errors++;
            $display("FAIL to_state: request=%b busy=%b done=%b required 0 0 0000", request, busy, done_vec);
        end
        slave_en = 1'b1;
        slave_d  = 2;
        data_vec = {3'd4, 3'd3, 3'd2, 3'd1};
        req_vec  = 4'b1111;
        wait_valid(ok);
        checks++;
        if (!ok || data_out !== 3'd3) begin
            errors++;
            $display("FAIL to_ptr_data: got %0d required 3", data_out);
        end
        wait_done(ok);
        checks++;
        if (!ok || done_vec !== 4'b0100 || err_vec !== 4'b0000) begin
            errors++;
            $display("FAIL to_ptr_done: done=%b err=%b required 0100 0000", done_vec, err_vec);
        end
        req_vec = '0;
        step();
        slave_en = 1'b0;
    endtask
`else
    task automatic test_no_timeout();
        bit ok;
        bit held;
        do_reset();
        data_vec = {3'd0, 3'd0, 3'd2, 3'd0};
        req_vec  = 4'b0010;
        step();
        held = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            if (request !== 1'b1 || err_vec !== 4'b0000 || valid !== 1'b0) held = 1'b0;
            step();
        end
        checks++;
        if (!held) begin
            errors++;
            $display("FAIL nto_hold: request=%b err=%b required request held 1, err 0000", request, err_vec);
        end
        ack_manual = 1'b1;
        wait_valid(ok);
        checks++;
        if (!ok || data_out !== 3'd2) begin
            errors++;
            $display("FAIL nto_data: got %0d required 2", data_out);
        end
        ack_manual = 1'b0;
        wait_done(ok);
        checks++;
        if (!ok || done_vec !== 4'b0010 || err_vec !== 4'b0000) begin
            errors++;
            $display("FAIL nto_done: done=%b err=%b required 0010 0000", done_vec, err_vec);
        end
        req_vec = '0;
        step();
    endtask
`endif

    initial begin
        errors     = 0;
        checks     = 0;
        rst_n      = 1'b0;
        slave_en   = 1'b0;
        slave_d    = 1;
        ack_manual = 1'b0;
        req_vec    = '0;
        data_vec   = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_data_latch();
        test_reset_mid_send();
`ifdef C2C_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
